gpio_poll_master: RTL and testbench

GPIO_POLL_MASTER -- requirements
Module: gpio_poll_master

---
 rtl/gpio_poll_pkg.sv | 15 +
 rtl/gpio_poll_debounce.sv | 46 ++++
 rtl/gpio_poll_master.sv | 131 +++++++++++++
 tb/tb_gpio_poll_master.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_poll_pkg.sv
// Shared types and bus widths for the GPIO polling master and its debounce helper.
package gpio_poll_pkg;

    localparam int AVM_ADDR_W = 2;
    localparam int AVM_DATA_W = 32;
    localparam int DB_CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_LAT  = 2'd2,
        ST_UPD  = 2'd3
    } state_e;

endpackage

// File: rtl/gpio_poll_debounce.sv
// Debounce filter: qualifies a raw read once DEBOUNCE_CNT consecutive identical values are seen.
// Only present when GPIO_POLL_DEBOUNCE_EN is defined.
`ifdef GPIO_POLL_DEBOUNCE_EN
module gpio_poll_debounce
    import gpio_poll_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int DEBOUNCE_CNT = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              raw_valid,
    input  logic [DATA_W-1:0] raw,
    output logic              stable
);

    logic [DATA_W-1:0]   last_q, last_d;
    logic [DB_CNT_W-1:0] cnt_q, cnt_d;

    // Saturating run-length of identical reads; a mismatch restarts the run at 1.
    always_comb begin
        last_d = last_q;
        cnt_d  = cnt_q;
        if (raw_valid) begin
            last_d = raw;
            if (raw != last_q)
                cnt_d = DB_CNT_W'(1);
            else if (cnt_q != '1)
                cnt_d = cnt_q + 1'b1;
        end
    end

    assign stable = raw_valid && (cnt_d >= DB_CNT_W'(DEBOUNCE_CNT));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= '0;
            cnt_q  <= '0;
        end else begin
            last_q <= last_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/gpio_poll_master.sv
// Periodic Avalon-MM read poller producing a sampled GPIO value with change/edge pulses.
// Define GPIO_POLL_DEBOUNCE_EN to filter samples through gpio_poll_debounce.
module gpio_poll_master
    import gpio_poll_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int PERIOD       = 1000,
    parameter int RD_ADDR      = 0,
    parameter int DEBOUNCE_CNT = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    output logic [AVM_ADDR_W-1:0] avm_address,
    output logic                  avm_read,
    input  logic                  avm_waitrequest,
    input  logic [AVM_DATA_W-1:0] avm_readdata,
    output logic [DATA_W-1:0]     sample,
    output logic                  sample_valid,
    output logic                  changed,
    output logic [DATA_W-1:0]     rise,
    output logic [DATA_W-1:0]     fall,
    output logic                  busy
);

    localparam int               TMR_W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(PERIOD - 1);

    if (DATA_W < 1 || DATA_W > AVM_DATA_W || PERIOD < 4 ||
        DEBOUNCE_CNT < 2 || DEBOUNCE_CNT > 15) begin : g_param_check
        $error("gpio_poll_master: parameter out of range");
    end

    state_e            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              pending_q, pending_d;
    logic              primed_q, primed_d;
    logic [DATA_W-1:0] raw_q, raw_d;
    logic [DATA_W-1:0] sample_q, sample_d;

    logic start_hit, start_req, consume, upd, take;
    logic unused_rd;

    assign unused_rd = ^avm_readdata;

    always_comb begin
        timer_d = timer_q - 1'b1;
        if (!enable || timer_q == '0)
            timer_d = TMR_LOAD;
    end

    // Wraps landing outside IDLE fold into a single pending start.
    assign start_hit = enable && (timer_q == '0);
    assign start_req = pending_q || start_hit;
    assign consume   = (state_q == ST_IDLE) && start_req && enable;
    assign pending_d = enable && start_req && !consume;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (consume)          state_d = ST_REQ;
            ST_REQ:  if (!avm_waitrequest) state_d = ST_LAT;
            ST_LAT:                        state_d = ST_UPD;
            ST_UPD:                        state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    assign upd = (state_q == ST_UPD);

`ifdef GPIO_POLL_DEBOUNCE_EN
    logic db_stable;

    gpio_poll_debounce #(
        .DATA_W       (DATA_W),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_debounce (
        .clk       (clk),
        .reset_n   (reset_n),
        .raw_valid (upd),
        .raw       (raw_q),
        .stable    (db_stable)
    );

    assign take = upd && db_stable;
`else
    assign take = upd;
`endif

    always_comb begin
        raw_d    = (state_q == ST_LAT) ? avm_readdata[DATA_W-1:0] : raw_q;
        sample_d = take ? raw_q : sample_q;
        primed_d = primed_q || take;
    end

    // Sample and edge outputs are presented during UPD so they line up with sample_valid.
    always_comb begin
        avm_read     = (state_q == ST_REQ);
        avm_address  = AVM_ADDR_W'(RD_ADDR);
        busy         = (state_q != ST_IDLE);
        sample_valid = upd;
        sample       = take ? raw_q : sample_q;
        changed      = take && primed_q && (raw_q != sample_q);
        rise         = changed ? (raw_q & ~sample_q) : '0;
        fall         = changed ? (~raw_q & sample_q) : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_q   <= TMR_LOAD;
            pending_q <= 1'b0;
            primed_q  <= 1'b0;
            raw_q     <= '0;
            sample_q  <= '0;
        end else begin
            timer_q   <= timer_d;
            pending_q <= pending_d;
            primed_q  <= primed_d;
            raw_q     <= raw_d;
            sample_q  <= sample_d;
        end
    end

endmodule

// File: tb/tb_gpio_poll_master.sv
// Scoreboard bench for gpio_poll_master (PERIOD=8, DATA_W=8); a latency-1 slave lives in the monitor.
// Build with GPIO_POLL_DEBOUNCE_EN to exercise the debounced variant.
module tb_gpio_poll_master;

    localparam int DATA_W  = 8;
    localparam int PERIOD  = 8;
    localparam int RD_ADDR = 2;
    localparam int DB_CNT  = 3;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              enable;
    logic              avm_waitrequest;
    logic [31:0]       avm_readdata = '0;
    logic [1:0]        avm_address;
    logic              avm_read;
    logic [DATA_W-1:0] sample, rise, fall;
    logic              sample_valid, changed, busy;

    gpio_poll_master #(
        .DATA_W       (DATA_W),
        .PERIOD       (PERIOD),
        .RD_ADDR      (RD_ADDR),
        .DEBOUNCE_CNT (DB_CNT)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .enable          (enable),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .sample          (sample),
        .sample_valid    (sample_valid),
        .changed         (changed),
        .rise            (rise),
        .fall            (fall),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] smp;
        logic              chg;
        logic [DATA_W-1:0] ris;
        logic [DATA_W-1:0] fal;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] data_q[$];

    int n_chk = 0, n_fail = 0;
    int cyc = 0, sv_cnt = 0, rd_cnt = 0, exp_rd_len = 1;
    int rd_hi = 0, acc_cyc = 0;
    bit acc_pend = 0;
    logic [31:0]       cur_rd = '0;
    logic [DATA_W-1:0] m_sample = '0, m_last = '0;
    logic              m_primed = 1'b0;
    int                m_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference behaviour for one completed read.
    task automatic model_step(input logic [DATA_W-1:0] raw);
        exp_t e;
        logic take;
`ifdef GPIO_POLL_DEBOUNCE_EN
        if (raw == m_last) begin
            if (m_cnt < 15) m_cnt++;
        end else begin
            m_cnt = 1;
        end
        m_last = raw;
        take   = (m_cnt >= DB_CNT);
`else
        take = 1'b1;
`endif
        e.smp = take ? raw : m_sample;
        e.chg = take && m_primed && (raw != m_sample);
        e.ris = e.chg ? (raw & ~m_sample) : '0;
        e.fal = e.chg ? (~raw & m_sample) : '0;
        if (take) begin
            m_sample = raw;
            m_primed = 1'b1;
        end
        exp_q.push_back(e);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Slave responder and output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            acc_pend = 0;
            rd_hi    = 0;
            m_sample = '0;
            m_last   = '0;
            m_primed = 1'b0;
            m_cnt    = 0;
        end else begin
            if (acc_pend) begin
                acc_pend = 0;
                if (data_q.size() > 0) cur_rd = data_q.pop_front();
                avm_readdata = cur_rd;
                model_step(cur_rd[DATA_W-1:0]);
            end
            if (avm_read) begin
                if (rd_hi == 0) rd_cnt++;
                rd_hi++;
                check("avm_address", 32'(avm_address), RD_ADDR);
                if (!avm_waitrequest) begin
                    acc_pend = 1;
                    acc_cyc  = cyc;
                end
            end else if (rd_hi != 0) begin
                check("rd_len", rd_hi, exp_rd_len);
                rd_hi = 0;
            end
            if (sample_valid) begin
                sv_cnt++;
                check("sv_latency", cyc - acc_cyc, 2);
                if (exp_q.size() == 0) begin
                    check("sb_underflow", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("sample",  32'(sample),  32'(e.smp));
                    check("changed", 32'(changed), 32'(e.chg));
                    check("rise",    32'(rise),    32'(e.ris));
                    check("fall",    32'(fall),    32'(e.fal));
                end
            end else begin
                check("changed_idle", {changed, rise, fall}, 0);
            end
        end
    end

    // Main-process tasks run at posedge+2.
    task automatic wait_read(output int t);
        int n = 0;
        t = -1;
        while (avm_read && n < 100) begin @(posedge clk); #2; n++; end
        while (!avm_read && n < 200) begin @(posedge clk); #2; n++; end
        if (avm_read) t = cyc;
        else check("rd_timeout", 32'(avm_read), 1);
    endtask

    task automatic wait_sv(input int target);
        int n = 0;
        while (sv_cnt < target && n < 300) begin @(posedge clk); #2; n++; end
        check("sv_timeout", 32'(sv_cnt >= target), 1);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_avm_read"}, 32'(avm_read), 0);
        check({tag, "_avm_addr"}, 32'(avm_address), RD_ADDR);
        check({tag, "_busy"},     32'(busy), 0);
        check({tag, "_sample"},   32'(sample), 0);
        check({tag, "_sv"},       32'(sample_valid), 0);
        check({tag, "_edges"},    {changed, rise, fall}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, ts, base;
        reset_n = 1'b0;
        enable = 1'b0;
        avm_waitrequest = 1'b0;
        #1;
        check_reset_outs("rst");
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;

        // Basic polling: one-cycle read every 8 cycles, first read 8 cycles after enable
        repeat (3) data_q.push_back(32'h0000_00A5);
        base = sv_cnt;
        enable = 1'b1;
        t0 = cyc;
        wait_read(t1);
        check("first_rd_gap", t1 - t0, 8);
        check("busy_req", 32'(busy), 1);
        t0 = t1; wait_read(t1); check("rd_gap", t1 - t0, 8);
        t0 = t1; wait_read(t1); check("rd_gap", t1 - t0, 8);
        wait_sv(base + 3);

        // Value change with junk in the ignored upper bits
        data_q.push_back(32'hFFFF_FF5A);
        t0 = t1; wait_read(t1); check("rd_gap", t1 - t0, 8);
        wait_sv(base + 4);

        // 20-cycle stall: REQ held 21 cycles, then one collapsed read right after UPD
        data_q.push_back(32'h0000_003C);
        data_q.push_back(32'h1234_56C3);
        avm_waitrequest = 1'b1;
        exp_rd_len = 21;
        t0 = t1; wait_read(ts); check("rd_gap", ts - t0, 8);
        repeat (20) @(posedge clk);
        #2 avm_waitrequest = 1'b0;
        wait_read(t1);
        exp_rd_len = 1;
        check("stall_extra_gap", t1 - ts, 24);
        data_q.push_back(32'h0000_00C3);
        t0 = t1; wait_read(t1); check("post_stall_gap", t1 - t0, 8);
        wait_sv(base + 7);

        // Enable dropped during LAT: read completes, then silence until re-enable
        data_q.push_back(32'h0000_0077);
        data_q.push_back(32'h0000_0088);
        t0 = t1; wait_read(t1); check("rd_gap", t1 - t0, 8);
        @(posedge clk); #2;
        enable = 1'b0;
        base = rd_cnt;
        wait_sv(sv_cnt + 1);
        repeat (30) @(posedge clk);
        #2 check("rd_while_off", rd_cnt - base, 0);
        enable = 1'b1;
        t0 = cyc;
        wait_read(t1);
        check("reenable_gap", t1 - t0, 8);
        wait_sv(sv_cnt + 1);

        // Reset while stalled in REQ
        avm_waitrequest = 1'b1;
        t0 = t1; wait_read(t1); check("rd_gap", t1 - t0, 8);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1 check_reset_outs("mid_rst");
        avm_waitrequest = 1'b0;
        @(posedge clk); #2;
        reset_n = 1'b1;
        t0 = cyc;
        data_q.push_back(32'h0000_0001);
        data_q.push_back(32'hABCD_EF00);
        data_q.push_back(32'h0000_0001);
        data_q.push_back(32'h0000_0001);
        data_q.push_back(32'h5500_0001);
        base = sv_cnt;
        wait_read(t1);
        check("post_rst_gap", t1 - t0, 8);

        // Debounce-shaped sequence 01,00,01,01,01
        wait_sv(base + 4);
`ifdef GPIO_POLL_DEBOUNCE_EN
        check("db_hold_4th", 32'(sample), 0);
`else
        check("nodb_4th", 32'(sample), 1);
`endif
        wait_sv(base + 5);
        check("seq_5th", 32'(sample), 1);

        // Random values
        for (int i = 0; i < 6; i++) data_q.push_back($urandom);
        wait_sv(base + 11);

        check("sb_left", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
